// File: rtl/fp32_nr_pkg.sv
// fp32_nr_pkg: shared constants and the normalize-to-round stage bundle
package fp32_nr_pkg;
  localparam int EXP_BIAS = 127;
  localparam int EXP_MAX = 255;
  localparam int FRAC_W = 23;
  localparam int MANT_W = 28;
  localparam int EXP_W = 10;
  localparam int EXP_IW = 12;
  typedef struct packed {
    logic sign;
    logic signed [EXP_IW-1:0] exp;
    logic [FRAC_W:0] mant;
    logic g;
    logic r;
    logic s;
    logic zero;
  } s1_t;
endpackage

// File: rtl/fpnr_lzc27.sv
// fpnr_lzc27: leading-zero count of a 27-bit vector with an all-zero flag
module fpnr_lzc27 (
  input  logic [26:0] a,
  output logic [4:0]  cnt,
  output logic        zero
);
  always_comb begin
    cnt = 5'd27;
    for (int i = 0; i < 27; i++) cnt = a[i] ? 5'(26 - i) : cnt;
  end
  assign zero = ~|a;
endmodule

// File: rtl/fp32_norm_round.sv
// fp32_norm_round: two-stage FP32 normalize/round-nearest-even/pack with valid/ready; define FPNR_SUBNORMAL_EN for gradual underflow
module fp32_norm_round
  import fp32_nr_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_sign,
  input  logic [EXP_W-1:0]  in_exp,
  input  logic [MANT_W-1:0] in_mant,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_result,
  output logic              out_overflow,
  output logic              out_underflow,
  output logic              out_inexact
);
  s1_t s1_d, s1_q;
  logic s1_v, s2_v, s2_take, all_zero, up, inx;
  logic [4:0] lz, sh;
  logic signed [EXP_IW-1:0] e_in, ef, er;
  logic [26:0] nm, m2, m;
  logic [24:0] sig;
  logic [7:0] fld;
  logic [34:0] res_d;
`ifdef FPNR_SUBNORMAL_EN
  logic signed [EXP_IW-1:0] lim, d;
  logic [4:0] rs;
  logic [57:0] ext;
  logic tiny;
`endif
  fpnr_lzc27 lzc (.a(in_mant[26:0]), .cnt(lz), .zero(all_zero));
  assign s2_take = !s2_v || out_ready;
  assign in_ready = !s1_v || s2_take;
  assign out_valid = s2_v;
  always_comb begin
    e_in = {{(EXP_IW-EXP_W){in_exp[EXP_W-1]}}, in_exp};
`ifdef FPNR_SUBNORMAL_EN
    lim = e_in > 12'sd1 ? e_in - 12'sd1 : '0;
    sh = $signed({7'd0, lz}) > lim ? lim[4:0] : lz;
`else
    sh = lz;
`endif
    nm = in_mant[27] ? {in_mant[27:2], |in_mant[1:0]} : in_mant[26:0] << sh;
    s1_d = '{sign: in_sign,
             exp: in_mant[27] ? e_in + 12'sd1 : e_in - $signed({7'd0, sh}),
             mant: nm[26:3], g: nm[2], r: nm[1], s: nm[0],
             zero: all_zero && !in_mant[27]};
  end
  always_comb begin
    m2 = {s1_q.mant, s1_q.g, s1_q.r, s1_q.s};
`ifdef FPNR_SUBNORMAL_EN
    d = 12'sd1 - s1_q.exp;
    rs = s1_q.exp > 12'sd0 ? 5'd0 : d > 12'sd31 ? 5'd31 : d[4:0];
    ext = {m2, 31'd0} >> rs;
    m = {ext[57:32], |ext[31:0]};
    ef = s1_q.exp > 12'sd0 ? s1_q.exp : 12'sd1;
    tiny = !m[26];
`else
    m = m2;
    ef = s1_q.exp;
`endif
    up = m[2] & (m[1] | m[0] | m[3]);
    sig = {1'b0, m[26:3]} + {24'd0, up};
    er = ef + {{(EXP_IW-1){1'b0}}, sig[24]};
    inx = |m[2:0];
    fld = (sig[24] | sig[23]) ? er[7:0] : 8'd0;
`ifdef FPNR_SUBNORMAL_EN
    res_d = s1_q.zero ? {3'b000, s1_q.sign, 31'd0}
          : er >= EXP_IW'(EXP_MAX) ? {3'b101, s1_q.sign, 8'hFF, 23'd0}
          : {1'b0, tiny & inx, inx, s1_q.sign, fld, sig[22:0]};
`else
    res_d = s1_q.zero ? {3'b000, s1_q.sign, 31'd0}
          : er >= EXP_IW'(EXP_MAX) ? {3'b101, s1_q.sign, 8'hFF, 23'd0}
          : er < 12'sd1 ? {3'b011, s1_q.sign, 31'd0}
          : {2'b00, inx, s1_q.sign, fld, sig[22:0]};
`endif
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_v <= 1'b0;
      s2_v <= 1'b0;
      s1_q <= '0;
      {out_overflow, out_underflow, out_inexact, out_result} <= '0;
    end else begin
      if (in_ready) begin
        s1_v <= in_valid;
        s1_q <= s1_d;
      end
      if (s2_take) begin
        s2_v <= s1_v;
        if (s1_v) {out_overflow, out_underflow, out_inexact, out_result} <= res_d;
      end
    end
  end
endmodule

// File: tb/tb_fp32_norm_round.sv
// tb_fp32_norm_round: randomized and directed checks of fp32_norm_round against an exact-arithmetic rounding model
module tb_fp32_norm_round;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0;
  logic in_ready;
  logic in_sign = 1'b0;
  logic [9:0] in_exp = '0;
  logic [27:0] in_mant = '0;
  logic out_valid;
  logic out_ready = 1'b0;
  logic [31:0] out_result;
  logic out_overflow, out_underflow, out_inexact;
  logic [34:0] obs;
  int checks = 0;
  int errors = 0;
  always #5 clk = ~clk;
  assign obs = {out_overflow, out_underflow, out_inexact, out_result};
  fp32_norm_round dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_sign(in_sign), .in_exp(in_exp), .in_mant(in_mant),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_overflow(out_overflow), .out_underflow(out_underflow), .out_inexact(out_inexact)
  );
  function automatic logic [34:0] ref_model(input logic s, input logic [9:0] e, input logic [27:0] m);
    int ex, p, be, eb, n;
    longint q, rem, half;
    logic inx, up;
    ex = int'($signed(e));
    if (m == 0) return {3'b000, s, 31'd0};
    p = 0;
    for (int i = 0; i < 28; i++) if (m[i]) p = i;
    be = ex + p - 26;
`ifdef FPNR_SUBNORMAL_EN
    eb = be < 1 ? 1 : be;
`else
    eb = be;
`endif
    n = eb + 3 - ex;
    inx = 1'b0;
    if (n <= 0) q = longint'(m) << (-n);
    else if (n >= 40) begin
      q = 0;
      inx = 1'b1;
    end else begin
      q = longint'(m) >> n;
      rem = longint'(m) - (q << n);
      half = longint'(1) << (n - 1);
      inx = rem != 0;
      up = rem > half || (rem == half && q[0]);
      q = q + longint'(up);
    end
    if (q >= (longint'(1) << 24)) begin
      q = q >> 1;
      eb++;
    end
    if (eb >= 255) return {3'b101, s, 8'hFF, 23'd0};
`ifdef FPNR_SUBNORMAL_EN
    return {1'b0, be < 1 && inx, inx, s, q >= (longint'(1) << 23) ? 8'(eb) : 8'd0, q[22:0]};
`else
    if (eb <= 0) return {3'b011, s, 31'd0};
    return {2'b00, inx, s, 8'(eb), q[22:0]};
`endif
  endfunction
  function automatic logic [9:0] rand_exp();
    int v;
    case ($urandom_range(3))
      0: v = int'($urandom_range(1023)) - 512;
      1: v = 100 + int'($urandom_range(60));
      2: v = 225 + int'($urandom_range(40));
      default: v = int'($urandom_range(60)) - 30;
    endcase
    return 10'(v);
  endfunction
  function automatic logic [27:0] rand_mant();
    logic [27:0] m;
    m = 28'($urandom);
    m = m >> $urandom_range(27);
    if ($urandom_range(3) == 0) m[2:0] = 3'b100;
    if ($urandom_range(15) == 0) m = '0;
    return m;
  endfunction
  task automatic test_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if ({out_valid, obs} !== 36'd0) begin
      errors++;
      $display("FAIL reset_outputs: got %h required 0", {out_valid, obs});
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    #1;
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready: got %b required 1", in_ready);
    end
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_out_valid: got %b required 0", out_valid);
    end
  endtask
  task automatic test_directed();
    logic [38:0] vin [7];
    logic [34:0] vexp [7];
    int cyc;
    vin = '{{1'b0, 10'd127, 28'h4000000}, {1'b0, 10'd127, 28'h8000000},
            {1'b0, 10'd127, 28'h4000004}, {1'b0, 10'd127, 28'h400000C},
            {1'b0, 10'd254, 28'h7FFFFFC}, {1'b1, 10'd1, 28'h2000000},
            {1'b1, 10'd100, 28'h0000000}};
    vexp = '{{3'b000, 32'h3F800000}, {3'b000, 32'h40000000},
             {3'b001, 32'h3F800000}, {3'b001, 32'h3F800002},
             {3'b101, 32'h7F800000},
`ifdef FPNR_SUBNORMAL_EN
             {3'b000, 32'h80400000},
`else
             {3'b011, 32'h80000000},
`endif
             {3'b000, 32'h80000000}};
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      out_ready = 1'b1;
      in_valid = 1'b1;
      {in_sign, in_exp, in_mant} = vin[i];
      @(negedge clk);
      in_valid = 1'b0;
      cyc = 1;
      while (!out_valid && cyc < 10) begin
        @(negedge clk);
        cyc++;
      end
      checks++;
      if (cyc != 2) begin
        errors++;
        $display("FAIL dir_latency[%0d]: got %0d cycles required 2", i, cyc);
      end
      checks++;
      if (obs !== vexp[i]) begin
        errors++;
        $display("FAIL dir_result[%0d]: got %h required %h", i, obs, vexp[i]);
      end
    end
    @(negedge clk);
  endtask
  task automatic test_backpressure();
    logic [38:0] b [4];
    logic [34:0] q [$];
    logic [34:0] hold;
    logic held = 1'b0;
    int sent = 0;
    int got = 0;
    int cyc = 0;
    for (int i = 0; i < 4; i++) b[i] = {1'($urandom), 10'(120 + $urandom_range(15)), 28'($urandom) | 28'h4000000};
    while (got < 4 && cyc < 40) begin
      @(negedge clk);
      cyc++;
      out_ready = cyc > 6;
      in_valid = sent < 4;
      if (sent < 4) {in_sign, in_exp, in_mant} = b[sent];
      #1;
      if (cyc <= 6) begin
        checks++;
        if (in_ready !== (sent < 2)) begin
          errors++;
          $display("FAIL bp_in_ready: cycle %0d got %b required %b", cyc, in_ready, sent < 2);
        end
        if (out_valid && !held) begin
          hold = obs;
          held = 1'b1;
        end else if (out_valid) begin
          checks++;
          if (obs !== hold) begin
            errors++;
            $display("FAIL bp_stable: got %h required %h", obs, hold);
          end
        end
      end
      if (out_valid) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL bp_out: unexpected beat %h, required no beat", obs);
        end else begin
          if (obs !== q[0]) begin
            errors++;
            $display("FAIL bp_out: got %h required %h", obs, q[0]);
          end
          if (out_ready) begin
            void'(q.pop_front());
            got++;
          end
        end
      end
      if (in_valid && in_ready) begin
        q.push_back(ref_model(in_sign, in_exp, in_mant));
        sent++;
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
    checks++;
    if (got != 4) begin
      errors++;
      $display("FAIL bp_drain: got %0d beats required 4", got);
    end
  endtask
  task automatic test_random(input int n);
    logic [34:0] q [$];
    logic acc = 1'b0;
    int sent = 0;
    int got = 0;
    int cyc = 0;
    while (got < n && cyc < 20 * n) begin
      @(negedge clk);
      cyc++;
      if (acc) in_valid = 1'b0;
      acc = 1'b0;
      if (!in_valid && sent < n && $urandom_range(3) != 0) begin
        in_valid = 1'b1;
        in_sign = 1'($urandom);
        in_exp = rand_exp();
        in_mant = rand_mant();
      end
      out_ready = $urandom_range(9) < 7;
      #1;
      if (out_valid) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL rand_out: unexpected beat %h, required no beat", obs);
        end else begin
          if (obs !== q[0]) begin
            errors++;
            $display("FAIL rand_out: got %h required %h", obs, q[0]);
          end
          if (out_ready) begin
            void'(q.pop_front());
            got++;
          end
        end
      end
      if (in_valid && in_ready) begin
        q.push_back(ref_model(in_sign, in_exp, in_mant));
        sent++;
        acc = 1'b1;
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
    checks++;
    if (got != n) begin
      errors++;
      $display("FAIL rand_drain: got %0d beats required %0d", got, n);
    end
  endtask
  task automatic test_reset_mid();
    out_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      {in_sign, in_exp, in_mant} = {1'b0, 10'd127, 28'h4000000 + 28'(i)};
    end
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    checks++;
    if ({in_ready, out_valid} !== 2'b01) begin
      errors++;
      $display("FAIL mid_full: got in_ready/out_valid %b required 01", {in_ready, out_valid});
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if ({out_valid, obs} !== 36'd0) begin
      errors++;
      $display("FAIL mid_reset: got %h required 0", {out_valid, obs});
    end
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      #1;
      checks++;
      if (out_valid !== 1'b0) begin
        errors++;
        $display("FAIL mid_ghost: cycle %0d got out_valid %b required 0", i, out_valid);
      end
    end
  endtask
  initial begin
    test_reset();
    test_directed();
    test_backpressure();
    test_random(400);
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
